// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader. The instruction
// ROM/RAM read side uses the same defaults.
//   - state_t       : loader FSM state encodings
//   - DEF_DEPTH     : instruction words held in imem
//   - DEF_CNT_W     : width of a word index (2**DEF_CNT_W >= DEF_DEPTH)
//   - DEF_BASE_ADDR : byte address of imem word 0
// ---------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int          DEF_DEPTH     = 1042;
    localparam int          DEF_CNT_W     = 11;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Byte-stream link from the host bridge (UART/JTAG) into the loader.
//   in_valid : byte available from the host
//   in_data  : byte value
//   in_ready : loader accepts the byte at the next rising clock edge
// Modports: master = host bridge side, slave = loader side.
// ---------------------------------------------------------------------------
interface imem_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/imem_word_packer.sv
// ---------------------------------------------------------------------------
// imem_word_packer
// Collects bytes little-endian into a 32-bit word: the first byte of a group
// of four ends up in word[7:0], the fourth in word[31:24].
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : drop any partially collected word (new load starting)
//   shift_en   : accept byte_in this cycle
//   byte_in    : incoming byte
//   word       : packed word register, stable while shift_en is low
//   word_full  : the byte accepted this cycle completes a word
// ---------------------------------------------------------------------------
module imem_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0] byte_cnt;

    // Bytes enter at the top lane and move down, so after four shifts the
    // first byte sits in the lowest lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word     <= 32'h0;
            byte_cnt <= 2'd0;
        end else if (clear) begin
            byte_cnt <= 2'd0;
        end else if (shift_en) begin
            word     <= {byte_in, word[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    assign word_full = shift_en && (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Loads word_cnt instruction words from a host byte stream into imem,
// writing word i at byte address BASE_ADDR + 4*i, and holds the CPU until
// the load finishes.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : pulse, begin a load (accepted only in IDLE/DONE)
//   word_cnt   : number of words, sampled with an accepted start
//   bus        : byte stream (slave side of imem_loader_if)
//   we, wa, wd : imem write port (one-cycle we pulse per word)
//   cpu_hold   : 1 while the core must stay stalled
//   busy       : 1 in LOAD/WRITE
//   done       : 1 in DONE
//   err        : last start was rejected because word_cnt was 0 or too big
// ---------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH     = DEF_DEPTH,
    parameter int          CNT_W     = DEF_CNT_W,
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W:0]   word_cnt,
    imem_loader_if.slave     bus,
    output logic             we,
    output logic [31:0]      wa,
    output logic [31:0]      wd,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   index;
    logic [CNT_W:0]     cnt_latched;
    logic               start_ok;
    logic               bad_cnt;
    logic               handshake;
    logic               word_full;
    logic               last_word;

    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign bad_cnt   = (word_cnt == '0) || (word_cnt > (CNT_W+1)'(DEPTH));
    assign handshake = bus.in_valid && (state == ST_LOAD);
    assign last_word = ({1'b0, index} == (cnt_latched - 1'b1));

    imem_word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_ok),
        .shift_en  (handshake),
        .byte_in   (bus.in_data),
        .word      (wd),
        .word_full (word_full)
    );

    // State register; the async reset drops we/in_ready in the same instant
    // because both are decoded straight from state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A rejected start parks in DONE so the host sees
    // done together with err and the core is released.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = bad_cnt ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (word_full) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_next = last_word ? ST_DONE : ST_LOAD;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Load bookkeeping: error flag, latched count, word index and the write
    // address, which is captured as the fourth byte arrives so it is stable
    // for the whole WRITE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err         <= 1'b0;
            cnt_latched <= '0;
            index       <= '0;
            wa          <= BASE_ADDR;
        end else begin
            if (start_ok) begin
                err <= bad_cnt;
                if (!bad_cnt) begin
                    cnt_latched <= word_cnt;
                    index       <= '0;
                end
            end
            if ((state == ST_LOAD) && word_full) begin
                wa <= BASE_ADDR + 32'({index, 2'b00});
            end
            if ((state == ST_WRITE) && !last_word) begin
                index <= index + 1'b1;
            end
        end
    end

    assign bus.in_ready = (state == ST_LOAD);
    assign we           = (state == ST_WRITE);
    assign busy         = (state == ST_LOAD) || (state == ST_WRITE);
    assign done         = (state == ST_DONE);
    assign cpu_hold     = (state != ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Scoreboard bench for imem_loader: every load pushes the expected
// (address, data) pairs into a queue; a monitor on the falling clock edge
// pops one entry for each we pulse and also keeps a model of imem.
// ---------------------------------------------------------------------------
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int CW = DEF_CNT_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW:0]   word_cnt = '0;
    logic          we;
    logic [31:0]   wa;
    logic [31:0]   wd;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          err;

    imem_loader_if bus ();

    imem_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .word_cnt (word_cnt),
        .bus      (bus.slave),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail = 0;
    int           write_count = 0;
    logic [31:0]  last_wa = 32'hFFFF_FFFF;
    logic [63:0]  exp_q[$];
    logic [31:0]  load_words[$];
    logic [31:0]  mem [0:DEF_DEPTH-1];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && we) begin
            logic [63:0] e;
            write_count++;
            last_wa = wa;
            if ((wa[1:0] == 2'b00) && ((wa >> 2) < DEF_DEPTH)) begin
                mem[wa >> 2] = wd;
            end
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_write: got wa=0x%08h wd=0x%08h, expected no write", wa, wd);
            end else begin
                e = exp_q.pop_front();
                checkOutput("write_addr", wa, e[63:32]);
                checkOutput("write_data", wd, e[31:0]);
            end
        end
    end

    task automatic startLoad(input int n);
        word_cnt = (CW+1)'(n);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    // Offer one byte and hold it until the loader takes it. With gaps set,
    // a random number of idle cycles (carrying junk data) precede it.
    task automatic sendByte(input logic [7:0] b, input bit gaps);
        int guard = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'hEE;
                @(posedge clk); #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.in_ready) begin
            checkOutput("byte_accept_timeout", 32'(bus.in_ready), 32'd1);
        end else begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    // Issue the bytes of load_words[0..n-1], pushing each expected write.
    task automatic applyStimulus(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({DEF_BASE_ADDR + 32'(4 * i), load_words[i]});
            for (int k = 0; k < 4; k++) begin
                sendByte(load_words[i][8*k +: 8], gaps);
            end
        end
    endtask

    task automatic waitDone(input string name);
        int guard = 0;
        while (!done && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput(name, 32'(done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          wc0;
        logic [31:0] word1_before;
        logic [31:0] ra;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset state while rst_n is held low
        #23;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst_we", 32'(we), 32'd0);
        checkOutput("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_wa", wa, 32'h0000_0000);
        checkOutput("rst_wd", wd, 32'h0000_0000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two-word back-to-back load
        $display("[TB] two-word load, back-to-back bytes");
        load_words = {32'h0000_0513, 32'h0010_0093};
        wc0 = write_count;
        startLoad(2);
        checkOutput("t2_busy", 32'(busy), 32'd1);
        checkOutput("t2_hold", 32'(cpu_hold), 32'd1);
        applyStimulus(2, 1'b0);
        @(posedge clk); #1;
        checkOutput("t2_done", 32'(done), 32'd1);
        checkOutput("t2_release", 32'(cpu_hold), 32'd0);
        checkOutput("t2_busy_off", 32'(busy), 32'd0);
        checkOutput("t2_ready_off", 32'(bus.in_ready), 32'd0);
        checkOutput("t2_queue", 32'(exp_q.size()), 32'd0);
        checkOutput("t2_writes", 32'(write_count - wc0), 32'd2);

        // Same load with gaps in the byte stream
        $display("[TB] two-word load with in_valid gaps");
        wc0 = write_count;
        startLoad(2);
        checkOutput("t3_hold", 32'(cpu_hold), 32'd1);
        applyStimulus(2, 1'b1);
        waitDone("t3_done");
        checkOutput("t3_writes", 32'(write_count - wc0), 32'd2);
        checkOutput("t3_queue", 32'(exp_q.size()), 32'd0);

        // Rejected counts, then a valid single-word load
        $display("[TB] rejected word counts");
        wc0 = write_count;
        startLoad(0);
        checkOutput("t4_err0", 32'(err), 32'd1);
        checkOutput("t4_done0", 32'(done), 32'd1);
        checkOutput("t4_busy0", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        startLoad(1043);
        checkOutput("t4_err1043", 32'(err), 32'd1);
        checkOutput("t4_done1043", 32'(done), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t4_no_writes", 32'(write_count - wc0), 32'd0);
        load_words = {32'hDEAD_BEEF};
        startLoad(1);
        checkOutput("t4_err_clear", 32'(err), 32'd0);
        checkOutput("t4_busy1", 32'(busy), 32'd1);
        applyStimulus(1, 1'b0);
        waitDone("t4_done1");
        checkOutput("t4_one_write", 32'(write_count - wc0), 32'd1);
        checkOutput("t4_wa", last_wa, 32'h0000_0000);

        // Full-depth load
        $display("[TB] full-depth load");
        load_words.delete();
        for (int i = 0; i < DEF_DEPTH; i++) begin
            load_words.push_back((32'(i) * 32'h9E37_79B9) ^ 32'h0F0F_0F0F);
        end
        wc0 = write_count;
        startLoad(DEF_DEPTH);
        applyStimulus(DEF_DEPTH, 1'b0);
        waitDone("t5_done");
        checkOutput("t5_writes", 32'(write_count - wc0), 32'd1042);
        checkOutput("t5_last_wa", last_wa, 32'h0000_1044);
        ra = 32'h0000_1044;
        checkOutput("t5_readback", mem[ra >> 2], load_words[DEF_DEPTH-1]);
        checkOutput("t5_queue", 32'(exp_q.size()), 32'd0);
        word1_before = load_words[1];

        // Reset in the middle of a three-word load
        $display("[TB] reset during load");
        load_words = {32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};
        wc0 = write_count;
        startLoad(3);
        applyStimulus(1, 1'b0);
        sendByte(8'h88, 1'b0);
        sendByte(8'h77, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("t6_we", 32'(we), 32'd0);
        checkOutput("t6_hold", 32'(cpu_hold), 32'd1);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_done", 32'(done), 32'd0);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("t6_writes", 32'(write_count - wc0), 32'd1);
        checkOutput("t6_word1_kept", mem[1], word1_before);
        checkOutput("t6_queue", 32'(exp_q.size()), 32'd0);
        startLoad(3);
        applyStimulus(3, 1'b0);
        waitDone("t6_reload_done");
        checkOutput("t6_word1_new", mem[1], 32'h5566_7788);
        checkOutput("t6_reload_writes", 32'(write_count - wc0), 32'd4);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
